// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low column strobe on the scan tick,
// builds a full-scan image of pressed keys and debounces it into one pulse per press.
module keypad_scanner #(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dclk,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAND      = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_e;

    logic [3:0]  row_meta_q;
    logic [3:0]  row_sync_q;
    logic [3:0]  col_q;
    logic [1:0]  col_idx_q;
    logic [11:0] scan_q;
    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cand_q;
    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic        key_held_q;

    logic        scan_done_s;
    logic [15:0] image_s;
    logic [4:0]  ones_s;
    logic        is_none_s;
    logic        is_single_s;
    logic [3:0]  single_code_s;
    logic [3:0]  cnt_inc_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Image bit c*4+r maps to the legend printed on that key.
    function automatic logic [3:0] key_of_index(input logic [3:0] idx);
        logic [3:0] k;
        case (idx)
            4'd0:    k = 4'h1;
            4'd1:    k = 4'h4;
            4'd2:    k = 4'h7;
            4'd3:    k = 4'h0;
            4'd4:    k = 4'h2;
            4'd5:    k = 4'h5;
            4'd6:    k = 4'h8;
            4'd7:    k = 4'hF;
            4'd8:    k = 4'h3;
            4'd9:    k = 4'h6;
            4'd10:   k = 4'h9;
            4'd11:   k = 4'hE;
            4'd12:   k = 4'hA;
            4'd13:   k = 4'hB;
            4'd14:   k = 4'hC;
            4'd15:   k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Classify the completed scan; the last column is taken straight from the synchronizer.
    always_comb begin
        scan_done_s   = dclk && (col_idx_q == 2'd3);
        image_s       = {~row_sync_q, scan_q};
        ones_s        = popcount16(image_s);
        is_none_s     = (ones_s == 5'd0);
        is_single_s   = (ones_s == 5'd1);
        single_code_s = key_of_index(lowest_index(image_s));
        cnt_inc_s     = cnt_q + 4'd1;
    end

    // Two-flop row synchronizer; idle rows read high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
        end
    end

    // Column walker and partial scan image.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q     <= 4'b1110;
            col_idx_q <= 2'd0;
            scan_q    <= 12'd0;
        end else if (dclk) begin
            case (col_idx_q)
                2'd0:    scan_q[3:0]  <= ~row_sync_q;
                2'd1:    scan_q[7:4]  <= ~row_sync_q;
                2'd2:    scan_q[11:8] <= ~row_sync_q;
                default: scan_q       <= 12'd0;
            endcase
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= {col_q[2:0], col_q[3]};
        end
    end

    // Debounce FSM stepped once per completed scan, with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_single_s) begin
                            cand_q <= single_code_s;
                            cnt_q  <= 4'd1;
                            if (DEB == 4'd1) begin
                                state_q     <= ST_PRESSED;
                                key_valid_q <= 1'b1;
                                key_code_q  <= single_code_s;
                                key_held_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CAND;
                            end
                        end
                    end
                    ST_CAND: begin
                        if (is_single_s && (single_code_s == cand_q)) begin
                            cnt_q <= cnt_inc_s;
                            if (cnt_inc_s == DEB) begin
                                state_q     <= ST_PRESSED;
                                key_valid_q <= 1'b1;
                                key_code_q  <= cand_q;
                                key_held_q  <= 1'b1;
                            end
                        end else if (is_single_s) begin
                            cand_q <= single_code_s;
                            cnt_q  <= 4'd1;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 4'd0;
                        end
                    end
                    ST_PRESSED: begin
                        // Any key activity keeps the press alive; no auto-repeat.
                        if (is_none_s) begin
                            cnt_q <= 4'd1;
                            if (DEB == 4'd1) begin
                                state_q    <= ST_IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= ST_RELEASING;
                            end
                        end
                    end
                    ST_RELEASING: begin
                        if (is_none_s) begin
                            cnt_q <= cnt_inc_s;
                            if (cnt_inc_s == DEB) begin
                                state_q    <= ST_IDLE;
                                cnt_q      <= 4'd0;
                                key_held_q <= 1'b0;
                            end
                        end else begin
                            state_q <= ST_PRESSED;
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= 4'd0;
                        key_held_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign COL       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a virtual keypad drives ROW from COL; directed scan
// tables plus random scans checked against a per-scan debounce model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dclk = 1'b0;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] pressed = 16'd0;
    int total = 0;
    int bad = 0;
    int pulses = 0;

    localparam int DEB = 4;
    localparam logic [15:0] K0 = 16'h0008, K1 = 16'h0001, K2 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020, K9 = 16'h0400, KD = 16'h8000;

    typedef struct {
        logic [15:0] keys;
        logic        ev;
        logic [3:0]  ec;
        logic        eh;
    } vec_t;
    vec_t tbl[$];

    logic [3:0] code_of [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                                 4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

    keypad_scanner #(.DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .dclk(dclk), .ROW(ROW),
        .COL(COL), .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Virtual keypad: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        case (COL)
            4'b1110: ROW = ~pressed[3:0];
            4'b1101: ROW = ~pressed[7:4];
            4'b1011: ROW = ~pressed[11:8];
            4'b0111: ROW = ~pressed[15:12];
            default: ROW = 4'hF;
        endcase
    end

    always @(posedge clk) if (key_valid) pulses++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_dclk();
        @(negedge clk) dclk = 1'b1;
        @(negedge clk) dclk = 1'b0;
    endtask

    task automatic run_scan(input logic [15:0] keys, input logic ev, input logic [3:0] ec,
                            input logic eh, input string tag);
        int p0;
        pressed = keys;
        repeat (2) @(negedge clk);
        p0 = pulses;
        for (int c = 0; c < 4; c++) begin
            pulse_dclk();
            if (c == 3) begin
                check({tag, " valid"}, {15'd0, key_valid}, {15'd0, ev});
                check({tag, " code"}, {12'd0, key_code}, {12'd0, ec});
                check({tag, " held"}, {15'd0, key_held}, {15'd0, eh});
            end
            repeat (3) @(negedge clk);
        end
        check({tag, " pulses"}, 16'(pulses - p0), {15'd0, ev});
    endtask

    task automatic add_run(input logic [15:0] k, input int n, input logic [3:0] c_pre,
                           input logic h_pre, input logic v_last, input logic [3:0] c_last,
                           input logic h_last);
        for (int i = 0; i < n - 1; i++) tbl.push_back('{k, 1'b0, c_pre, h_pre});
        tbl.push_back('{k, v_last, c_last, h_last});
    endtask

    task automatic do_reset();
        pressed = 16'd0;
        @(negedge clk) rst_n = 1'b0;
        repeat (2) pulse_dclk();
        check("rst COL", {12'd0, COL}, 16'h000E);
        check("rst valid", {15'd0, key_valid}, 16'd0);
        check("rst code", {12'd0, key_code}, 16'd0);
        check("rst held", {15'd0, key_held}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] keys, prev;
        logic [3:0]  cand, code, kidx;
        int run, nrun, ones, p0;
        logic held, ev;
        logic [3:0] exp_col;

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            pulse_dclk();
            exp_col = ~(4'b0001 << (i % 4));
            check("col walk", {12'd0, COL}, {12'd0, exp_col});
            repeat (3) @(negedge clk);
        end
        repeat (2) begin pulse_dclk(); repeat (3) @(negedge clk); end
        do_reset();

        add_run(K5, 4, 4'h0, 1'b0, 1'b1, 4'h5, 1'b1);
        add_run(K5, 2, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1);
        add_run(16'd0, 4, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            add_run(K9, 1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
            add_run(16'd0, 1, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
        end
        add_run(K1 | K2, 2, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0);
        add_run(K1, 4, 4'h5, 1'b0, 1'b1, 4'h1, 1'b1);
        add_run(16'd0, 4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0);
        add_run(KD, 4, 4'h1, 1'b0, 1'b1, 4'hD, 1'b1);
        add_run(16'd0, 4, 4'hD, 1'b1, 1'b0, 4'hD, 1'b0);
        add_run(K0, 4, 4'hD, 1'b0, 1'b1, 4'h0, 1'b1);
        add_run(16'd0, 2, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
        add_run(K0, 4, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
        add_run(K0 | KD, 2, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
        add_run(16'd0, 4, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
        add_run(K2, 2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        add_run(K1, 4, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1);
        add_run(16'd0, 4, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0);
        foreach (tbl[i]) run_scan(tbl[i].keys, tbl[i].ev, tbl[i].ec, tbl[i].eh, "table");

        // Reset while the candidate has three matching scans.
        for (int i = 0; i < 3; i++) run_scan(K5, 1'b0, 4'h1, 1'b0, "pre-rst");
        p0 = pulses;
        do_reset();
        check("rst no pulse", 16'(pulses - p0), 16'd0);
        pressed = K5;
        for (int i = 0; i < 3; i++) run_scan(K5, 1'b0, 4'h0, 1'b0, "requal");
        run_scan(K5, 1'b1, 4'h5, 1'b1, "requal last");
        for (int i = 0; i < 4; i++) run_scan(16'd0, 1'b0, 4'h5, (i < 3) ? 1'b1 : 1'b0, "requal rel");

        // Random scans against a run-length model of the debounce rules.
        do_reset();
        held = 1'b0; cand = 4'd0; code = 4'd0; run = 0; nrun = 0; prev = 16'd0;
        for (int s = 0; s < 200; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: keys = prev;
                5, 6:          keys = 16'd0;
                7, 8:          keys = 16'd1 << $urandom_range(0, 15);
                default:       keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            endcase
            prev = keys;
            ones = $countones(keys);
            kidx = 4'd0;
            for (int b = 0; b < 16; b++) if (keys[b]) kidx = 4'(b);
            ev = 1'b0;
            if (!held) begin
                if (ones == 1) begin
                    if (run > 0 && kidx == cand) run++;
                    else begin cand = kidx; run = 1; end
                    if (run == DEB) begin ev = 1'b1; held = 1'b1; code = code_of[kidx]; nrun = 0; end
                end else run = 0;
            end else begin
                if (ones == 0) begin
                    nrun++;
                    if (nrun == DEB) begin held = 1'b0; run = 0; end
                end else nrun = 0;
            end
            run_scan(keys, ev, code, held, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scanned 4x4 hex keypad reader for guess entry in the 1A2B game, the input-side counterpart of the multiplexed seven-segment driver. It walks an active-low column strobe on the shared scan tick, reads active-low rows back, debounces across whole scans, and emits one `key_valid` pulse with a 4-bit hex `key_code` per debounced press. It sits between the Pmod keypad pins and the game controller.

## Interface
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; legal range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `dclk`  in  1  scan tick, one-`clk` pulse; successive pulses at least 4 `clk` apart.
- `ROW`  in  4  keypad rows, active-low, asynchronous to `clk`.
- `COL`  out  4  column strobe, active-low, exactly one bit low.
- `key_valid`  out  1  one-cycle pulse on an accepted press.
- `key_code`  out  4  hex value of the last accepted key; held between presses.
- `key_held`  out  1  high while a debounced key is down.

## Operation
- `ROW` passes through a 2-flop synchronizer (`row_s`) before any use.
- Column sequence `COL`: 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing on each `dclk`.
- On each `dclk`: sample `~row_s` for the current column into a 16-bit scan image, then advance `COL`. The `dclk` that samples column 0111 completes a scan.
- Key map, column index c (0 = `COL` 1110), row index r (0 = `ROW[0]`):
  - c0 rows 0..3 = 1, 4, 7, 0
  - c1 rows 0..3 = 2, 5, 8, F
  - c2 rows 0..3 = 3, 6, 9, E
  - c3 rows 0..3 = A, B, C, D
- Scan classification:
  - NONE: 0 bits set.
  - SINGLE(code): exactly 1 bit set.
  - MULTI: 2 or more bits set.
- Debounce FSM, evaluated only at scan completion; 4-bit counter `cnt`:
  - IDLE
    - SINGLE(k): cand = k, cnt = 1 -> CAND; if `DEBOUNCE_SCANS` = 1, go directly to PRESSED.
    - NONE or MULTI: stay in IDLE.
  - CAND
    - SINGLE(cand): cnt + 1; when cnt reaches `DEBOUNCE_SCANS` -> PRESSED, pulse `key_valid`, `key_code` = cand.
    - SINGLE(other): restart, cand = other, cnt = 1.
    - NONE or MULTI: -> IDLE.
  - PRESSED (`key_held` = 1)
    - NONE: cnt = 1 -> RELEASING; if `DEBOUNCE_SCANS` = 1, go directly to IDLE.
    - SINGLE (any code) or MULTI: stay. No auto-repeat; a second key is never registered while one is held.
  - RELEASING (`key_held` = 1)
    - NONE: cnt + 1; when cnt reaches `DEBOUNCE_SCANS` -> IDLE.
    - SINGLE or MULTI: -> PRESSED, no pulse.
- `key_code` changes only together with a `key_valid` pulse.

## Timing
- Reset values (`rst_n` low at a `clk` edge): `COL` = 1110, `key_valid` = 0, `key_code` = 0, `key_held` = 0, FSM = IDLE, cnt = 0, scan image cleared.
- `dclk` is ignored on any cycle where `rst_n` is low.
- Reset mid-press or mid-scan: no pulse is emitted, and the scan restarts at column 0.
- Outputs are registered. `key_valid` is high on the cycle after the completing `dclk` edge, for exactly 1 cycle. `key_code` and `key_held` update on that same cycle.
- Input latency: a `ROW` change is visible to sampling 2 `clk` cycles later. Rows are sampled at the end of each column slot, so each slot has at least 4 `clk` of settle time.
- Press latency: the first scan that sees the key, plus `DEBOUNCE_SCANS` - 1 further scans, plus 1 `clk`.
- Release: `key_held` falls 1 `clk` after the `DEBOUNCE_SCANS`-th consecutive NONE scan.

## Test plan
- Reset: hold `rst_n` low while pulsing `dclk` -> `COL` = 1110, all outputs 0. After release, 8 `dclk` pulses -> `COL` 1110, 1101, 1011, 0111, 1110, ... with the wrap.
- Press '5' (`ROW[1]` low while `COL` = 1101) for 6 scans, `DEBOUNCE_SCANS` = 4 -> exactly one `key_valid`, 1 `clk` after the 4th scan completes; `key_code` = 4'h5; `key_held` = 1.
- Bounce: '9' present in alternating scans for 12 scans -> no `key_valid`; `key_held` stays 0.
- Press 1 and 2 together (`ROW[0]` low in c0 and c1) -> MULTI, no `key_valid`. Release '2' while holding '1' -> one pulse with `key_code` = 4'h1 after 4 SINGLE scans.
- Hold 'D', release for 4 scans, then press '0' -> two pulses with codes 4'hD then 4'h0. `key_held` drops between them. With only a 2-scan gap (key seen again in RELEASING), the second press gives no pulse.
- Reset mid-press: assert `rst_n` low during CAND at cnt = 3 -> no pulse, outputs at reset values. The key must then be re-qualified over 4 full scans.
